// File: rtl/ift_op_pkg.sv
// ift_op_pkg
// Shared definitions for the IFT operator arbiter:
//   - opcode encodings for the shared binary operator (OP_AND .. OP_LT)
//   - FSM state encodings and the state enum used by ift_op_arbiter
package ift_op_pkg;

    // Opcodes of the shared binary operator
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_XNOR = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_EQ   = 3'd6;
    localparam logic [2:0] OP_LT   = 3'd7;

    // FSM state encodings, also available as plain constants
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        RESP = ST_RESP
    } state_e;

endpackage

// File: rtl/ift_binop.sv
// ift_binop
// Purely combinational binary operator with information-flow taint
// propagation. The result taint is the bitwise OR of both operand taints
// for every opcode.
// Ports:
//   op   in  3        opcode (see ift_op_pkg)
//   a, b in  WIDTH    operands
//   a_t, b_t in TAINT_W operand taints
//   y    out WIDTH    result (ADD/SUB wrap, EQ/LT zero-extended)
//   y_t  out TAINT_W  result taint
module ift_binop
    import ift_op_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TAINT_W = 32
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [TAINT_W-1:0] a_t,
    input  logic [TAINT_W-1:0] b_t,
    output logic [WIDTH-1:0]   y,
    output logic [TAINT_W-1:0] y_t
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_EQ:   y[0] = (a == b);
            OP_LT:   y[0] = (a < b);
            default: y = '0;
        endcase
    end

    // Conservative propagation: any tainted input bit taints the result
    assign y_t = a_t | b_t;

endmodule

// File: rtl/ift_op_arbiter.sv
// ift_op_arbiter
// Two-requester round-robin arbiter in front of one shared IFT binary
// operator. A request is latched in IDLE, executed in EXEC and held as a
// response in RESP until consumed. Delivered responses with a non-zero
// taint are counted in a saturating counter.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    per-requester handshake (ready is one-hot or 0)
//   req_op                 2 x 3-bit opcode, packed [i*3 +: 3]
//   req_a, req_b           2 x WIDTH operands
//   req_a_t, req_b_t       2 x TAINT_W operand taints
//   rsp_valid/rsp_ready    response handshake
//   rsp_id                 requester owning the response
//   rsp_data, rsp_data_t   result and result taint
//   tainted_cnt            saturating count of tainted delivered responses
module ift_op_arbiter
    import ift_op_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TAINT_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*3-1:0]         req_op,
    input  logic [2*WIDTH-1:0]     req_a,
    input  logic [2*WIDTH-1:0]     req_b,
    input  logic [2*TAINT_W-1:0]   req_a_t,
    input  logic [2*TAINT_W-1:0]   req_b_t,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [TAINT_W-1:0]     rsp_data_t,
    output logic [CNT_W-1:0]       tainted_cnt
);

    // Per-requester views of the packed request fields
    logic [2:0]         op_arr  [2];
    logic [WIDTH-1:0]   a_arr   [2];
    logic [WIDTH-1:0]   b_arr   [2];
    logic [TAINT_W-1:0] a_t_arr [2];
    logic [TAINT_W-1:0] b_t_arr [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        assign op_arr[gi]  = req_op[gi*3 +: 3];
        assign a_arr[gi]   = req_a[gi*WIDTH +: WIDTH];
        assign b_arr[gi]   = req_b[gi*WIDTH +: WIDTH];
        assign a_t_arr[gi] = req_a_t[gi*TAINT_W +: TAINT_W];
        assign b_t_arr[gi] = req_b_t[gi*TAINT_W +: TAINT_W];
    end

    state_e             state_reg, state_next;
    logic               last_grant_reg;
    logic [2:0]         op_reg;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [TAINT_W-1:0] a_t_reg, b_t_reg;
    logic               id_reg;
    logic               rsp_id_reg;
    logic [WIDTH-1:0]   rsp_data_reg;
    logic [TAINT_W-1:0] rsp_data_t_reg;
    logic [CNT_W-1:0]   tainted_cnt_reg, tainted_cnt_next;

    logic               grant_id;
    logic               grant_en;
    logic               rsp_fire;
    logic [WIDTH-1:0]   op_y;
    logic [TAINT_W-1:0] op_y_t;

    // Round robin: with both requesters valid the one not granted last time
    // wins; otherwise the single valid requester wins.
    always_comb begin
        grant_id = req_valid[1];
        if (req_valid == 2'b11) begin
            grant_id = ~last_grant_reg;
        end
    end

    assign grant_en  = (state_reg == IDLE) && (req_valid != 2'b00);
    assign req_ready = grant_en ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_fire  = (state_reg == RESP) && rsp_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_en) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter holds at all-ones instead of wrapping
    always_comb begin
        tainted_cnt_next = tainted_cnt_reg;
        if (rsp_fire && (rsp_data_t_reg != '0) && (tainted_cnt_reg != '1)) begin
            tainted_cnt_next = tainted_cnt_reg + CNT_W'(1);
        end
    end

    ift_binop #(
        .WIDTH   (WIDTH),
        .TAINT_W (TAINT_W)
    ) u_binop (
        .op  (op_reg),
        .a   (a_reg),
        .b   (b_reg),
        .a_t (a_t_reg),
        .b_t (b_t_reg),
        .y   (op_y),
        .y_t (op_y_t)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            last_grant_reg  <= 1'b1;
            op_reg          <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            a_t_reg         <= '0;
            b_t_reg         <= '0;
            id_reg          <= 1'b0;
            rsp_id_reg      <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_data_t_reg  <= '0;
            tainted_cnt_reg <= '0;
        end else begin
            state_reg       <= state_next;
            tainted_cnt_reg <= tainted_cnt_next;
            if (grant_en) begin
                last_grant_reg <= grant_id;
                id_reg         <= grant_id;
                op_reg         <= op_arr[grant_id];
                a_reg          <= a_arr[grant_id];
                b_reg          <= b_arr[grant_id];
                a_t_reg        <= a_t_arr[grant_id];
                b_t_reg        <= b_t_arr[grant_id];
            end
            // Response registers are only written in EXEC, so they stay
            // stable for the whole RESP stall.
            if (state_reg == EXEC) begin
                rsp_id_reg     <= id_reg;
                rsp_data_reg   <= op_y;
                rsp_data_t_reg <= op_y_t;
            end
        end
    end

    assign rsp_valid   = (state_reg == RESP);
    assign rsp_id      = rsp_id_reg;
    assign rsp_data    = rsp_data_reg;
    assign rsp_data_t  = rsp_data_t_reg;
    assign tainted_cnt = tainted_cnt_reg;

endmodule

// File: tb/tb_ift_op_arbiter.sv
// tb_ift_op_arbiter
// Directed bench for ift_op_arbiter. A second instance with CNT_W=2 shares
// all inputs with the main instance so that counter saturation can be
// observed alongside the normal 16-bit counter.
module tb_ift_op_arbiter;

    localparam int WIDTH   = 8;
    localparam int TAINT_W = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req_valid;
    logic [5:0]           req_op;
    logic [2*WIDTH-1:0]   req_a, req_b;
    logic [2*TAINT_W-1:0] req_a_t, req_b_t;
    logic                 rsp_ready;

    logic [1:0]           req_ready;
    logic                 rsp_valid, rsp_id;
    logic [WIDTH-1:0]     rsp_data;
    logic [TAINT_W-1:0]   rsp_data_t;
    logic [15:0]          tainted_cnt;

    logic [1:0]           sat_req_ready;
    logic                 sat_rsp_valid, sat_rsp_id;
    logic [WIDTH-1:0]     sat_rsp_data;
    logic [TAINT_W-1:0]   sat_rsp_data_t;
    logic [1:0]           sat_tainted_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ift_op_arbiter #(.WIDTH(WIDTH), .TAINT_W(TAINT_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_a_t(req_a_t), .req_b_t(req_b_t),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_data_t(rsp_data_t), .tainted_cnt(tainted_cnt)
    );

    ift_op_arbiter #(.WIDTH(WIDTH), .TAINT_W(TAINT_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(sat_req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_a_t(req_a_t), .req_b_t(req_b_t),
        .rsp_valid(sat_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(sat_rsp_id),
        .rsp_data(sat_rsp_data), .rsp_data_t(sat_rsp_data_t),
        .tainted_cnt(sat_tainted_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [31:0] at, input logic [31:0] bt);
        req_op[i*3 +: 3]           = op;
        req_a[i*WIDTH +: WIDTH]     = a;
        req_b[i*WIDTH +: WIDTH]     = b;
        req_a_t[i*TAINT_W +: TAINT_W] = at;
        req_b_t[i*TAINT_W +: TAINT_W] = bt;
    endtask

    // Wait (bounded) for a grant, check which requester got it, then take
    // the accepting edge. Returns at #1 after that edge (EXEC).
    task automatic wait_grant(input logic [1:0] exp);
        #1;
        for (int k = 0; k < 10 && req_ready == 2'b00; k++) begin
            @(posedge clk); #1;
        end
        chk("grant", req_ready, exp);
        @(posedge clk); #1;
        chk("exec_ready", req_ready, 2'b00);
    endtask

    // From EXEC, step into RESP and check the response contents.
    task automatic get_rsp(input logic id, input logic [7:0] data, input logic [31:0] t);
        chk("exec_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_id", rsp_id, id);
        chk("rsp_data", rsp_data, data);
        chk("rsp_data_t", rsp_data_t, t);
    endtask

    task automatic handshake(input logic [15:0] exp_cnt);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_valid", rsp_valid, 1'b0);
        chk("tainted_cnt", tainted_cnt, exp_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
        req_op = '0; req_a = '0; req_b = '0; req_a_t = '0; req_b_t = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_cnt", tainted_cnt, 16'd0);
        chk("rst_data", rsp_data, 8'h00);
        rst = 1'b0;

        // Single ADD from requester 0: 0xF0 + 0x20 wraps to 0x10
        set_req(0, 3'd4, 8'hF0, 8'h20, 32'h1, 32'h0);
        req_valid = 2'b01;
        wait_grant(2'b01);
        req_valid = 2'b00;
        get_rsp(1'b0, 8'h10, 32'h1);
        handshake(16'd1);

        // Untainted LT from requester 1: 3 < 5 -> 1, count unchanged
        set_req(1, 3'd7, 8'd3, 8'd5, 32'h0, 32'h0);
        req_valid = 2'b10;
        wait_grant(2'b10);
        req_valid = 2'b00;
        get_rsp(1'b1, 8'h01, 32'h0);
        handshake(16'd1);

        // Backpressure: req0 XOR held in RESP 5 cycles while req1 waits
        set_req(0, 3'd2, 8'hFF, 8'h0F, 32'h8000_0000, 32'h0);
        set_req(1, 3'd5, 8'h05, 8'h07, 32'h0, 32'h2);
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        wait_grant(2'b01);
        req_valid = 2'b11;
        get_rsp(1'b0, 8'hF0, 32'h8000_0000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_data", rsp_data, 8'hF0);
            chk("stall_t", rsp_data_t, 32'h8000_0000);
            chk("stall_ready", req_ready, 2'b00);
        end
        req_valid = 2'b10;
        handshake(16'd2);
        wait_grant(2'b10);
        req_valid = 2'b00;
        get_rsp(1'b1, 8'hFE, 32'h2);
        handshake(16'd3);

        // Reset while a response is pending
        set_req(0, 3'd0, 8'h0F, 8'hFF, 32'h4, 32'h0);
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        wait_grant(2'b01);
        req_valid = 2'b00;
        get_rsp(1'b0, 8'h0F, 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", rsp_valid, 1'b0);
        chk("arst_data", rsp_data, 8'h00);
        chk("arst_t", rsp_data_t, 32'h0);
        chk("arst_cnt", tainted_cnt, 16'd0);
        chk("arst_sat_cnt", sat_tainted_cnt, 2'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Contention: grants alternate 0,1,0,1 starting with requester 0
        set_req(0, 3'd0, 8'hCC, 8'hAA, 32'h0, 32'h0);
        set_req(1, 3'd1, 8'h0F, 8'h30, 32'h0, 32'h0);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                wait_grant(2'b01);
                get_rsp(1'b0, 8'h88, 32'h0);
            end else begin
                wait_grant(2'b10);
                get_rsp(1'b1, 8'h3F, 32'h0);
            end
            handshake(16'd0);
        end
        req_valid = 2'b00;

        // Saturation: 5 tainted XOR responses; the CNT_W=2 copy stops at 3
        set_req(0, 3'd2, 8'h55, 8'hFF, 32'h8000_0000, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            req_valid = 2'b01;
            wait_grant(2'b01);
            req_valid = 2'b00;
            get_rsp(1'b0, 8'hAA, 32'h8000_0000);
            handshake(16'(k));
            chk("sat_cnt", sat_tainted_cnt, (k > 3) ? 2'd3 : 2'(k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
